spi_frame_scheduler: RTL

Sequences 24-bit words into the `SPI_state_machine` transmitter and shares it between two requesters. Arbitrates requesters round-robin into a small tagged FIFO, launches one SPI frame per word, and tracks frame completion from `spi_cs_l`. Enforces a minimum inter-frame gap and flags engines that fail to start. Sits between the configuration and sample sources and the SPI engine's `data_in`.

---
 rtl/spi_sched_pkg.sv | 19 +
 rtl/spi_sched_fifo.sv | 44 ++++
 rtl/spi_frame_scheduler.sv | 135 +++++++++++++
 3 files changed

// File: rtl/spi_sched_pkg.sv
// spi_sched_pkg: shared types and default parameters for the SPI frame scheduler.
package spi_sched_pkg;
    localparam int DEF_DATA_W        = 24;
    localparam int DEF_FIFO_DEPTH    = 4;
    localparam int DEF_GAP_CYCLES    = 2;
    localparam int DEF_START_TIMEOUT = 63;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_GAP
    } state_t;

    typedef struct packed {
        logic                  src;
        logic [DEF_DATA_W-1:0] data;
    } entry_t;
endpackage

// File: rtl/spi_sched_fifo.sv
// spi_sched_fifo: synchronous tagged FIFO of {src, data} entries with level tracking.
module spi_sched_fifo
    import spi_sched_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     i_clk,
    input  logic                     i_reset_l,
    input  logic                     i_push,
    input  entry_t                   i_data,
    input  logic                     i_pop,
    output entry_t                   o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    entry_t        r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;

    always_ff @(posedge i_clk or negedge i_reset_l) begin
        if (!i_reset_l) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_level == (AW+1)'(DEPTH);
    assign o_empty = r_level == '0;
    assign o_level = r_level;
endmodule

// File: rtl/spi_frame_scheduler.sv
// spi_frame_scheduler: round-robin arbitration of two word sources into a FIFO that
// feeds one SPI frame at a time, with completion tracking, inter-frame gap and start timeout.
module spi_frame_scheduler
    import spi_sched_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
    input  logic                          i_clk,
    input  logic                          i_reset_l,
    input  logic                          i_req0_valid,
    input  logic [DATA_W-1:0]             i_req0_data,
    input  logic                          i_req1_valid,
    input  logic [DATA_W-1:0]             i_req1_data,
    output logic                          o_req0_ready,
    output logic                          o_req1_ready,
    output logic [DATA_W-1:0]             o_spi_data_in,
    output logic                          o_spi_start,
    input  logic                          i_spi_cs_l,
    output logic                          o_frame_done,
    output logic                          o_frame_src,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_err_timeout,
    input  logic                          i_err_clr
);
    localparam int CNT_MAX = START_TIMEOUT > GAP_CYCLES ? START_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_rr_favor1;
    logic               r_spi_start;
    logic [DATA_W-1:0]  r_spi_data_in;
    logic               r_src;
    logic               r_frame_done;
    logic               r_frame_src;
    logic               r_err_timeout;
    logic               w_can_push;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_pop;
    logic               w_sampling;
    logic               w_cs_low;
    logic               w_timeout;
    logic               w_done;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    entry_t             w_push_entry;
    entry_t             w_head;

    // Arbiter: a full FIFO still accepts a word in the cycle it is being popped.
    always_comb begin
        w_can_push   = i_reset_l && (!w_fifo_full || w_pop);
        w_gnt0       = w_can_push && i_req0_valid && (!i_req1_valid || !r_rr_favor1);
        w_gnt1       = w_can_push && i_req1_valid && (!i_req0_valid || r_rr_favor1);
        w_push_entry = '{src: w_gnt1, data: w_gnt1 ? i_req1_data : i_req0_data};
    end

    spi_sched_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_l (i_reset_l),
        .i_push    (w_gnt0 | w_gnt1),
        .i_data    (w_push_entry),
        .i_pop     (w_pop),
        .o_data    (w_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_level   (o_fifo_level)
    );

    // The shared counter restarts on every state change: timeout in WAIT_LOW, gap in GAP.
    always_ff @(posedge i_clk or negedge i_reset_l) begin
        if (!i_reset_l) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      w_next = w_fifo_empty ? S_IDLE : S_WAIT_LOW;
            S_WAIT_LOW:  w_next = w_cs_low ? S_WAIT_HIGH : w_timeout ? S_GAP : S_WAIT_LOW;
            S_WAIT_HIGH: w_next = w_done ? S_GAP : S_WAIT_HIGH;
            S_GAP:       w_next = (r_cnt == CNT_W'(GAP_CYCLES)) ? S_IDLE : S_GAP;
        endcase
    end

    // Chip-select is ignored during the launch cycle itself.
    always_comb begin
        w_pop      = r_state == S_IDLE && !w_fifo_empty;
        w_sampling = r_state == S_WAIT_LOW && !r_spi_start;
        w_cs_low   = w_sampling && !i_spi_cs_l;
        w_timeout  = w_sampling && i_spi_cs_l && r_cnt == CNT_W'(START_TIMEOUT - 1);
        w_done     = r_state == S_WAIT_HIGH && i_spi_cs_l;
    end

    always_ff @(posedge i_clk or negedge i_reset_l) begin
        if (!i_reset_l) begin
            r_rr_favor1   <= 1'b0;
            r_spi_start   <= 1'b0;
            r_spi_data_in <= '0;
            r_src         <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_src   <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_gnt0 | w_gnt1) r_rr_favor1 <= w_gnt0;
            r_spi_start <= w_pop;
            if (w_pop) begin
                r_spi_data_in <= w_head.data;
                r_src         <= w_head.src;
            end
            r_frame_done <= w_done;
            if (w_done || w_timeout) r_frame_src <= r_src;
            r_err_timeout <= w_timeout ? 1'b1 : i_err_clr ? 1'b0 : r_err_timeout;
        end
    end

    assign o_req0_ready  = w_gnt0;
    assign o_req1_ready  = w_gnt1;
    assign o_spi_data_in = r_spi_data_in;
    assign o_spi_start   = r_spi_start;
    assign o_frame_done  = r_frame_done;
    assign o_frame_src   = r_frame_src;
    assign o_err_timeout = r_err_timeout;
endmodule
